esm_retire_reorder: RTL
=======================

// Module: esm_retire_reorder
// PURPOSE
//  In-order retirement end of the ESM shuffle path. Allocates slot indices in program order,
//  accepts completions in the shuffled (random) order the execution side produces, and releases
//  slot indices strictly in original order. Sits between the shuffled executor and commit.
// PARAMETERS
//  bs     16  number of slots; power of two, >=2
//  IDX_W  $clog2(bs)  slot index width (derived, not overridden)
// PORTS
//  clk           in   1        clock, all state on rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  flush         in   1        synchronous discard of all in-flight slots
//  alloc_valid   in   1        issue side requests a new slot
//  alloc_ready   out  1        slot available (count<bs, not flushing)
//  alloc_index   out  IDX_W    index granted on alloc handshake (= tail)
//  done_valid    in   1        executor reports a slot complete
//  done_index    in   IDX_W    completed slot (arbitrary/shuffled order)
//  retire_valid  out  1        oldest slot is complete and may retire
//  retire_ready  in   1        commit accepts retirement
//  retire_index  out  IDX_W    oldest slot index (= head)
//  occupancy     out  IDX_W+1  number of allocated, unretired slots
//  err           out  1        illegal completion pulse (ESM_RETIRE_CHECK_EN only)
// BEHAVIOUR
//  - State: head, tail (IDX_W, wrap mod bs), count (IDX_W+1), alloc_bits[bs], done_bits[bs], FSM.
//  - Reset (rst_n=0, async): head=tail=0, count=0, all bits 0, FSM=RUN; outputs: alloc_ready=1,
//    alloc_index=0, retire_valid=0, retire_index=0, occupancy=0, err=0.
//  - FSM: RUN -> FLUSH when flush=1; FLUSH clears head=tail=count=0 and all bits in one cycle,
//    alloc_ready=0 and retire_valid=0 while in FLUSH; FLUSH -> RUN next cycle if flush=0, else stays.
//  - Alloc handshake (alloc_valid&&alloc_ready): set alloc_bits[tail], clear done_bits[tail], tail++.
//    alloc_ready = (FSM==RUN) && (count<bs); full (count==bs) blocks alloc, no overwrite.
//  - Completion: done_valid with alloc_bits[done_index]=1 and done_bits=0 sets done_bits[done_index].
//    Completion of an unallocated or already-done slot is ignored (state unchanged).
//  - retire_valid = (FSM==RUN) && count!=0 && done_bits[head]; combinational from registers.
//    Retire handshake: clear alloc_bits[head], done_bits[head], head++.
//  - Latency: done at cycle N for the head slot -> retire_valid at N+1. Alloc at N -> slot
//    completable from N+1 (done same cycle as its alloc is illegal/ignored).
//  - Simultaneous alloc+retire: count unchanged; both pointers advance. At full, retire frees a
//    slot only from the next cycle (alloc_ready registered-state based, no same-cycle bypass).
//  - Simultaneous done and retire of different slots: both take effect.
//  - flush with other events same cycle: flush wins; alloc/done/retire that cycle discarded.
//  - Pointers wrap bs-1 -> 0 with no gap; occupancy = count.
// CONFIGURATION
//  ESM_RETIRE_CHECK_EN defined: err pulses 1 cycle (registered, cycle after) for each ignored
//   completion (unallocated or duplicate); also asserts err if retire_ready while !retire_valid
//   is NOT an error (ignored). Undefined: err tied 0, no check logic synthesized.
// STRUCTURE
//  - esm_pkg: IDX_W function of bs, FSM state typedef {RUN, FLUSH}, pointer increment helper.
//  - One sub-module: esm_wrap_ptr (IDX_W register, inc enable, sync clear, async rst_n), used
//    for head and tail. Bitmaps and FSM stay in the top.
// TESTING (bs=16)
//  - Reset: drive rst_n=0 mid-traffic -> all outputs at reset values immediately, occupancy=0.
//  - Alloc 4 (indices 0,1,2,3), done order 2,0,3,1 -> retires 0 after done0, then 1,2,3
//    back-to-back after done1; occupancy returns to 0.
//  - Fill 16 -> alloc_ready=0 at occupancy=16; complete+retire idx 0 -> alloc_ready=1 next
//    cycle, next alloc_index=0 (wrap).
//  - retire_ready=0 with head done -> retire_valid held, retire_index stable; release -> 1 retire.
//  - Duplicate done_index=5 and done on unallocated 9 -> state unchanged; with
//    ESM_RETIRE_CHECK_EN err pulses twice, without it err stays 0.
//  - flush with 7 in flight plus same-cycle alloc/retire -> next cycle occupancy=0, head=tail=0,
//    alloc_ready=0 during FLUSH, 1 the cycle after flush drops.

Source files
------------

// File: rtl/esm_pkg.sv
// Shared definitions for the ESM in-order retirement block.
//   idx_width() : slot index width for a given slot count
//   esm_state_t : retirement FSM states
//   ptr_inc()   : slot pointer increment with wrap (slot count is a power of two)
package esm_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } esm_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic logic [31:0] ptr_inc(input logic [31:0] p, input int unsigned n);
    return (p + 32'd1) & (n - 32'd1);
  endfunction

endpackage

// File: rtl/esm_wrap_ptr.sv
// Wrapping slot pointer used for the head and tail of the reorder window.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (wins over inc)
//   inc        : advance by one, wrapping bs-1 -> 0
//   ptr        : current pointer value
module esm_wrap_ptr
  import esm_pkg::*;
#(
  parameter  int unsigned bs    = 16,
  localparam int unsigned IDX_W = idx_width(bs)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= IDX_W'(ptr_inc(32'(ptr), bs));
    end
  end

endmodule

// File: rtl/esm_retire_reorder.sv
// In-order retirement end of the ESM shuffle path. Slots are allocated in
// program order, completed in any order, and retired strictly in allocation order.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   flush                       : discard all in-flight slots (wins over all other events)
//   alloc_valid/ready/index     : slot allocation handshake, index = tail
//   done_valid, done_index      : completion report from the shuffled executor
//   retire_valid/ready/index    : in-order retirement handshake, index = head
//   occupancy                   : allocated, unretired slot count
//   err                         : one-cycle pulse per ignored completion when
//                                 ESM_RETIRE_CHECK_EN is defined, otherwise tied 0
module esm_retire_reorder
  import esm_pkg::*;
#(
  parameter  int unsigned bs    = 16,
  localparam int unsigned IDX_W = idx_width(bs)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_index,
  input  logic             done_valid,
  input  logic [IDX_W-1:0] done_index,
  output logic             retire_valid,
  input  logic             retire_ready,
  output logic [IDX_W-1:0] retire_index,
  output logic [IDX_W:0]   occupancy,
  output logic             err
);

  localparam logic [IDX_W:0] BS_CNT = (IDX_W+1)'(bs);

  esm_state_t       state;
  logic [IDX_W:0]   count;
  logic [bs-1:0]    alloc_bits;
  logic [bs-1:0]    done_bits;
  logic [bs-1:0]    alloc_bits_nx;
  logic [bs-1:0]    done_bits_nx;
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic             alloc_fire;
  logic             retire_fire;
  logic             done_legal;

  // Handshake qualifiers depend on registered state only.
  assign alloc_ready  = (state == RUN) && (count < BS_CNT);
  assign retire_valid = (state == RUN) && (count != '0) && done_bits[head];
  assign alloc_index  = tail;
  assign retire_index = head;
  assign occupancy    = count;

  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign retire_fire = retire_valid && retire_ready && !flush;
  assign done_legal  = alloc_bits[done_index] && !done_bits[done_index];

  esm_wrap_ptr #(.bs(bs)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (retire_fire),
    .ptr   (head)
  );

  esm_wrap_ptr #(.bs(bs)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (alloc_fire),
    .ptr   (tail)
  );

  // Head and tail only alias when empty (no retire) or full (no alloc), so the
  // retire-clear and alloc-set below never touch the same slot in one cycle.
  always_comb begin
    alloc_bits_nx = alloc_bits;
    done_bits_nx  = done_bits;
    if (retire_fire) begin
      alloc_bits_nx[head] = 1'b0;
      done_bits_nx[head]  = 1'b0;
    end
    if (alloc_fire) begin
      alloc_bits_nx[tail] = 1'b1;
      done_bits_nx[tail]  = 1'b0;
    end
    if (done_valid && done_legal) begin
      done_bits_nx[done_index] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      count      <= '0;
      alloc_bits <= '0;
      done_bits  <= '0;
    end else if (flush) begin
      state      <= FLUSH;
      count      <= '0;
      alloc_bits <= '0;
      done_bits  <= '0;
    end else begin
      state      <= RUN;
      alloc_bits <= alloc_bits_nx;
      done_bits  <= done_bits_nx;
      case ({alloc_fire, retire_fire})
        2'b10:   count <= count + (IDX_W+1)'(1);
        2'b01:   count <= count - (IDX_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ESM_RETIRE_CHECK_EN
  // Completions discarded by a same-cycle flush are not reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= done_valid && !flush && !done_legal;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
